// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// master = CPU requester side, slave = arbiter side.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32
);
   logic                  a_req;
   logic                  a_rw;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  a_ack;
   logic                  b_req;
   logic                  b_rw;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  b_ack;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  mem_enable;
   logic                  mem_rw;
   logic [ADDR_WIDTH-1:0] mem_addr;

   modport master (
      output a_req, a_rw, a_addr, a_wdata, b_req, b_rw, b_addr, b_wdata,
      input  a_ack, b_ack, rdata, mem_enable, mem_rw, mem_addr
   );

   modport slave (
      input  a_req, a_rw, a_addr, a_wdata, b_req, b_rw, b_addr, b_wdata,
      output a_ack, b_ack, rdata, mem_enable, mem_rw, mem_addr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the negedge-sampling single-ported mem.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (A wins).
module mem_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   mem_arbiter_if.slave               bus,
   inout  wire logic [DATA_WIDTH-1:0] mem_data
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state, state_nxt;
   logic                  win_b, win_b_nxt;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
   logic [DATA_WIDTH-1:0] rdata_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic                  en_nxt, rw_nxt, a_ack_nxt, b_ack_nxt;
   logic                  grant_b;

`ifdef MEM_ARB_RR_EN
   logic last_b, last_b_nxt;
   // On a tie the port not served last wins; uncontested grants go to whoever asks.
   assign grant_b = bus.b_req & (~bus.a_req | ~last_b);
`else
   assign grant_b = bus.b_req & ~bus.a_req;
`endif

   // Write data is held posedge-to-posedge so it spans the negedge that mem samples.
   assign mem_data = (bus.mem_enable && bus.mem_rw) ? wdata_q : 'z;

   always_comb begin
      state_nxt  = state;
      win_b_nxt  = win_b;
      wdata_nxt  = wdata_q;
      rdata_nxt  = bus.rdata;
      addr_nxt   = bus.mem_addr;
      en_nxt     = bus.mem_enable;
      rw_nxt     = bus.mem_rw;
      a_ack_nxt  = 1'b0;
      b_ack_nxt  = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_b_nxt = last_b;
`endif
      unique case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               win_b_nxt = grant_b;
               rw_nxt    = grant_b ? bus.b_rw    : bus.a_rw;
               addr_nxt  = grant_b ? bus.b_addr  : bus.a_addr;
               wdata_nxt = grant_b ? bus.b_wdata : bus.a_wdata;
               en_nxt    = 1'b1;
               state_nxt = ACCESS;
`ifdef MEM_ARB_RR_EN
               last_b_nxt = grant_b;
`endif
            end else begin
               en_nxt = 1'b0;
            end
         end
         ACCESS: begin
            if (!bus.mem_rw) rdata_nxt = mem_data;
            a_ack_nxt = ~win_b;
            b_ack_nxt = win_b;
            en_nxt    = 1'b0;
            rw_nxt    = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         win_b          <= 1'b0;
         wdata_q        <= '0;
         bus.rdata      <= '0;
         bus.mem_addr   <= '0;
         bus.mem_enable <= 1'b0;
         bus.mem_rw     <= 1'b0;
         bus.a_ack      <= 1'b0;
         bus.b_ack      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_b         <= 1'b1;
`endif
      end else begin
         state          <= state_nxt;
         win_b          <= win_b_nxt;
         wdata_q        <= wdata_nxt;
         bus.rdata      <= rdata_nxt;
         bus.mem_addr   <= addr_nxt;
         bus.mem_enable <= en_nxt;
         bus.mem_rw     <= rw_nxt;
         bus.a_ack      <= a_ack_nxt;
         bus.b_ack      <= b_ack_nxt;
`ifdef MEM_ARB_RR_EN
         last_b         <= last_b_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, saturation sequence, and
// randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

   localparam int AW = 24;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   wire [DW-1:0] mem_data;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .mem_data (mem_data)
   );

   always #5 clk = ~clk;

   // Stand-in for the mem block: acts on the falling edge.
   logic [DW-1:0] mem_arr [0:255];
   logic [DW-1:0] mem_rd = '0;
   assign mem_data = (bus.mem_enable && !bus.mem_rw) ? mem_rd : 'z;
   initial for (int i = 0; i < 256; i++) mem_arr[i] = '0;
   always @(negedge clk) begin
      if (bus.mem_enable) begin
         if (bus.mem_rw) mem_arr[bus.mem_addr[7:0]] <= mem_data;
         else            mem_rd <= mem_arr[bus.mem_addr[7:0]];
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic rst;
      logic a_req, a_rw; logic [AW-1:0] a_addr; logic [DW-1:0] a_wdata;
      logic b_req, b_rw; logic [AW-1:0] b_addr; logic [DW-1:0] b_wdata;
      logic x_aack, x_back, x_en, x_rw;
      logic [AW-1:0] x_addr; logic [DW-1:0] x_rdata; logic [DW-1:0] x_md;
   } vec_t;

   function automatic vec_t V(logic rst,
         logic ar, logic aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
         logic br, logic bw, logic [AW-1:0] ba, logic [DW-1:0] bd,
         logic xaa, logic xba, logic xen, logic xrw,
         logic [AW-1:0] xaddr, logic [DW-1:0] xrd, logic [DW-1:0] xmd);
      vec_t v;
      v.rst = rst;
      v.a_req = ar; v.a_rw = aw; v.a_addr = aa; v.a_wdata = ad;
      v.b_req = br; v.b_rw = bw; v.b_addr = ba; v.b_wdata = bd;
      v.x_aack = xaa; v.x_back = xba; v.x_en = xen; v.x_rw = xrw;
      v.x_addr = xaddr; v.x_rdata = xrd; v.x_md = xmd;
      return v;
   endfunction

   task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      bus.a_req = ar; bus.a_rw = aw; bus.a_addr = aa; bus.a_wdata = ad;
      bus.b_req = br; bus.b_rw = bw; bus.b_addr = ba; bus.b_wdata = bd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level reference state for the random phase
   logic          m_busy, m_win_b, m_rw, m_last_b;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data, m_rdata;
   logic [DW-1:0] expm [0:255];

   vec_t tbl [$];

   initial begin
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      reset_n = 1'b0;

      // Reset held with no requests
      for (int unsigned i = 0; i < 5; i++) begin
         tick();
         chk("rst_en",   bus.mem_enable, 0);
         chk("rst_rw",   bus.mem_rw, 0);
         chk("rst_addr", bus.mem_addr, 0);
         chk("rst_acks", {bus.a_ack, bus.b_ack}, 0);
         chk("rst_rdata", bus.rdata, 0);
      end
      reset_n = 1'b1;

      // A write/read, reset during B write, tie, rdata hold across writes
      tbl.push_back(V(1, 1,1,5,32'hDEADBEEF, 0,0,0,0,            0,0,1,1,5,0,32'hDEADBEEF));
      tbl.push_back(V(1, 1,1,5,32'hDEADBEEF, 0,0,0,0,            1,0,0,0,5,0,0));
      tbl.push_back(V(1, 1,0,5,0,            0,0,0,0,            0,0,1,0,5,0,0));
      tbl.push_back(V(1, 1,0,5,0,            0,0,0,0,            1,0,0,0,5,32'hDEADBEEF,0));
      tbl.push_back(V(1, 0,0,0,0,            0,0,0,0,            0,0,0,0,5,32'hDEADBEEF,0));
      tbl.push_back(V(1, 0,0,0,0,            1,1,7,32'hA5A5A5A5, 0,0,1,1,7,32'hDEADBEEF,32'hA5A5A5A5));
      tbl.push_back(V(0, 0,0,0,0,            1,1,7,32'hA5A5A5A5, 0,0,0,0,0,0,0));
      tbl.push_back(V(1, 0,0,0,0,            1,1,7,32'hA5A5A5A5, 0,0,1,1,7,0,32'hA5A5A5A5));
      tbl.push_back(V(1, 0,0,0,0,            1,1,7,32'hA5A5A5A5, 0,1,0,0,7,0,0));
      tbl.push_back(V(1, 0,0,0,0,            0,0,0,0,            0,0,0,0,7,0,0));
      tbl.push_back(V(1, 1,0,1,0,            1,1,2,32'h12345678, 0,0,1,0,1,0,0));
      tbl.push_back(V(1, 1,0,1,0,            1,1,2,32'h12345678, 1,0,0,0,1,0,0));
      tbl.push_back(V(1, 0,0,0,0,            1,1,2,32'h12345678, 0,0,1,1,2,0,32'h12345678));
      tbl.push_back(V(1, 0,0,0,0,            1,1,2,32'h12345678, 0,1,0,0,2,0,0));
      tbl.push_back(V(1, 0,0,0,0,            0,0,0,0,            0,0,0,0,2,0,0));
      tbl.push_back(V(1, 0,0,0,0,            1,1,3,32'hCAFEF00D, 0,0,1,1,3,0,32'hCAFEF00D));
      tbl.push_back(V(1, 0,0,0,0,            1,1,3,32'hCAFEF00D, 0,1,0,0,3,0,0));
      tbl.push_back(V(1, 1,0,3,0,            0,0,0,0,            0,0,1,0,3,0,0));
      tbl.push_back(V(1, 1,0,3,0,            0,0,0,0,            1,0,0,0,3,32'hCAFEF00D,0));
      tbl.push_back(V(1, 0,0,0,0,            1,1,4,32'h11111111, 0,0,1,1,4,32'hCAFEF00D,32'h11111111));
      tbl.push_back(V(1, 0,0,0,0,            1,1,4,32'h11111111, 0,1,0,0,4,32'hCAFEF00D,0));
      tbl.push_back(V(1, 1,1,6,32'h22222222, 0,0,0,0,            0,0,1,1,6,32'hCAFEF00D,32'h22222222));
      tbl.push_back(V(1, 1,1,6,32'h22222222, 0,0,0,0,            1,0,0,0,6,32'hCAFEF00D,0));
      tbl.push_back(V(1, 1,0,2,0,            0,0,0,0,            0,0,1,0,2,32'hCAFEF00D,0));
      tbl.push_back(V(1, 1,0,2,0,            0,0,0,0,            1,0,0,0,2,32'h12345678,0));
      tbl.push_back(V(1, 0,0,0,0,            0,0,0,0,            0,0,0,0,2,32'h12345678,0));

      foreach (tbl[i]) begin
         reset_n = tbl[i].rst;
         drive(tbl[i].a_req, tbl[i].a_rw, tbl[i].a_addr, tbl[i].a_wdata,
               tbl[i].b_req, tbl[i].b_rw, tbl[i].b_addr, tbl[i].b_wdata);
         tick();
         chk($sformatf("v%0d_a_ack", i), bus.a_ack, tbl[i].x_aack);
         chk($sformatf("v%0d_b_ack", i), bus.b_ack, tbl[i].x_back);
         chk($sformatf("v%0d_en", i),    bus.mem_enable, tbl[i].x_en);
         chk($sformatf("v%0d_rw", i),    bus.mem_rw, tbl[i].x_rw);
         chk($sformatf("v%0d_addr", i),  bus.mem_addr, tbl[i].x_addr);
         chk($sformatf("v%0d_rdata", i), bus.rdata, tbl[i].x_rdata);
         if (tbl[i].x_en && tbl[i].x_rw)
            chk($sformatf("v%0d_mdata", i), mem_data, tbl[i].x_md);
      end

      // Saturation: both ports request every cycle from a fresh reset
      reset_n = 1'b0;
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      tick();
      reset_n = 1'b1;
      drive(1, 0, 24'h10, '0, 1, 0, 24'h11, '0);
      for (int unsigned e = 1; e <= 16; e++) begin
         tick();
         if (e % 2 == 0) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("sat%0d_a_ack", e), bus.a_ack, ((e / 2) % 2) == 1);
            chk($sformatf("sat%0d_b_ack", e), bus.b_ack, ((e / 2) % 2) == 0);
`else
            chk($sformatf("sat%0d_a_ack", e), bus.a_ack, 1);
            chk($sformatf("sat%0d_b_ack", e), bus.b_ack, 0);
`endif
         end else begin
            chk($sformatf("sat%0d_noack", e), {bus.a_ack, bus.b_ack}, 0);
         end
      end

      // Randomized traffic against the transaction model
      reset_n = 1'b0;
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      tick();
      reset_n = 1'b1;
      m_busy = 0; m_win_b = 0; m_rw = 0; m_last_b = 1; m_addr = '0; m_data = '0; m_rdata = '0;
      for (int i = 0; i < 256; i++) expm[i] = mem_arr[i];
      for (int unsigned cyc = 0; cyc < 2000; cyc++) begin
         logic ar, br, ea, eb, take_b;
         ar = bus.a_req; br = bus.b_req;
         ea = 0; eb = 0;
         tick();
         if (m_busy) begin
            ea = ~m_win_b; eb = m_win_b;
            if (m_rw) expm[m_addr[7:0]] = m_data;
            else      m_rdata = expm[m_addr[7:0]];
            m_busy = 0;
         end else if (ar || br) begin
`ifdef MEM_ARB_RR_EN
            take_b = (ar && br) ? !m_last_b : br;
`else
            take_b = ar ? 1'b0 : 1'b1;
`endif
            m_last_b = take_b;
            m_win_b  = take_b;
            m_rw     = take_b ? bus.b_rw    : bus.a_rw;
            m_addr   = take_b ? bus.b_addr  : bus.a_addr;
            m_data   = take_b ? bus.b_wdata : bus.a_wdata;
            m_busy   = 1;
         end
         chk("rnd_a_ack", bus.a_ack, ea);
         chk("rnd_b_ack", bus.b_ack, eb);
         chk("rnd_en", bus.mem_enable, m_busy);
         chk("rnd_rdata", bus.rdata, m_rdata);
         if (m_busy) begin
            chk("rnd_addr", bus.mem_addr, m_addr);
            chk("rnd_rw", bus.mem_rw, m_rw);
            if (m_rw) chk("rnd_mdata", mem_data, m_data);
         end
         if (ea || !bus.a_req) begin
            bus.a_req = ($urandom_range(0, 1) == 1);
            bus.a_rw = $urandom_range(0, 1) == 1;
            bus.a_addr = AW'($urandom_range(32, 47));
            bus.a_wdata = $urandom;
         end
         if (eb || !bus.b_req) begin
            bus.b_req = ($urandom_range(0, 1) == 1);
            bus.b_rw = $urandom_range(0, 1) == 1;
            bus.b_addr = AW'($urandom_range(32, 47));
            bus.b_wdata = $urandom;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
